// File: rtl/connect4_game_ctrl.sv
// Connect-4 pop-out sequencer: owns board/cursor/scores, drops or pops pieces, scans for fours.
// Latency: drop 1..ROWS cycles, pop 1+ROWS-1 cycles, then COLS*ROWS check + 1 resolve; keys outside IDLE/OVER are dropped.
module connect4_game_ctrl #(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int SCORE_W = 4
) (
    input  logic                    clock,
    input  logic                    resetGame_n,
    input  logic                    keyValid,
    input  logic [3:0]              keypadButton,
    input  logic                    resetScore,
    output logic [COLS*ROWS-1:0]    boardPiece,
    output logic [COLS*ROWS-1:0]    boardSide,
    output logic [2:0]              currColumn,
    output logic                    currPlayer,
    output logic                    busy,
    output logic                    gameOver,
    output logic [1:0]              winner,
    output logic [SCORE_W-1:0]      scoreRed,
    output logic [SCORE_W-1:0]      scoreYellow
);

    localparam int NCELL = COLS * ROWS;
    localparam int IDX_W = $clog2(NCELL);
    localparam int ROW_W = $clog2(ROWS + 1);

    localparam logic [3:0] KEY_LEFT  = 4'h4;
    localparam logic [3:0] KEY_RIGHT = 4'h6;
    localparam logic [3:0] KEY_DROP  = 4'h5;
    localparam logic [3:0] KEY_POP   = 4'h8;
    localparam logic [3:0] KEY_NEW   = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE, S_DROP, S_POP, S_SHIFT, S_CHECK, S_RESOLVE, S_OVER
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             rst_sync;
    logic                   rst_int_n;
    logic [NCELL-1:0]       piece_q, side_q;
    logic [2:0]             cur_col_q, act_col_q, chk_c_q;
    logic [ROW_W-1:0]       row_q, chk_r_q;
    logic                   player_q, win_r_q, win_y_q, busy_q, over_q;
    logic [1:0]             winner_q;
    logic [SCORE_W-1:0]     score_r_q, score_y_q;

    logic [IDX_W-1:0]       cur_idx, above_idx, top_idx, bot_idx;
    logic                   cur_empty, row_last, shift_last, chk_last;
    logic                   pop_ok, board_full, line_r, line_y;
    logic                   red_wins, yel_wins;

    function automatic logic [IDX_W-1:0] cell_idx(input int c, input int r);
        return IDX_W'(c * ROWS + r);
    endfunction

    // Assert asynchronously, release on the clock so every flop leaves reset together.
    always_ff @(posedge clock or negedge resetGame_n) begin
        if (!resetGame_n) rst_sync <= 2'b00;
        else              rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign cur_idx    = cell_idx(int'(act_col_q), int'(row_q));
    assign above_idx  = cell_idx(int'(act_col_q), (row_q == ROW_W'(ROWS-1)) ? int'(row_q) : int'(row_q) + 1);
    assign top_idx    = cell_idx(int'(act_col_q), ROWS - 1);
    assign bot_idx    = cell_idx(int'(act_col_q), 0);
    assign cur_empty  = !piece_q[cur_idx];
    assign row_last   = (row_q == ROW_W'(ROWS-1));
    assign shift_last = (row_q == ROW_W'(ROWS-2));
    assign chk_last   = (chk_c_q == 3'(COLS-1)) && (chk_r_q == ROW_W'(ROWS-1));
    assign pop_ok     = piece_q[bot_idx] && (side_q[bot_idx] == player_q);
    assign board_full = &piece_q;

    // Four-in-a-row starting at the scan cell: right, up, up-right, down-right.
    always_comb begin
        int               dc, dr, cc, rr;
        logic             all_r, all_y;
        logic [IDX_W-1:0] ci;
        line_r = 1'b0;
        line_y = 1'b0;
        dc = 0; dr = 0; cc = 0; rr = 0;
        all_r = 1'b0; all_y = 1'b0;
        ci = '0;
        for (int d = 0; d < 4; d++) begin
            dc = (d == 1) ? 0 : 1;
            dr = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
            all_r = 1'b1;
            all_y = 1'b1;
            for (int i = 0; i < 4; i++) begin
                cc = int'(chk_c_q) + dc * i;
                rr = int'(chk_r_q) + dr * i;
                if (cc >= 0 && cc < COLS && rr >= 0 && rr < ROWS) begin
                    ci    = cell_idx(cc, rr);
                    all_r = all_r & piece_q[ci] & ~side_q[ci];
                    all_y = all_y & piece_q[ci] & side_q[ci];
                end else begin
                    all_r = 1'b0;
                    all_y = 1'b0;
                end
            end
            line_r = line_r | all_r;
            line_y = line_y | all_y;
        end
    end

    // A pop can complete fours for both sides; the mover takes the game then.
    assign red_wins = (win_r_q && win_y_q) ? !player_q : (win_r_q && !win_y_q);
    assign yel_wins = (win_r_q && win_y_q) ?  player_q : (win_y_q && !win_r_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (keyValid && keypadButton == KEY_DROP)     state_d = S_DROP;
                else if (keyValid && keypadButton == KEY_POP) state_d = S_POP;
            end
            S_DROP: begin
                if (cur_empty)     state_d = S_CHECK;
                else if (row_last) state_d = S_IDLE;
            end
            S_POP:     state_d = pop_ok ? S_SHIFT : S_IDLE;
            S_SHIFT:   if (shift_last) state_d = S_CHECK;
            S_CHECK:   if (chk_last) state_d = S_RESOLVE;
            S_RESOLVE: state_d = (win_r_q || win_y_q || board_full) ? S_OVER : S_IDLE;
            S_OVER:    if (keyValid && keypadButton == KEY_NEW) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= !(state_d inside {S_IDLE, S_OVER});
            over_q  <= (state_d == S_OVER);
        end
    end

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            piece_q   <= '0;
            side_q    <= '0;
            cur_col_q <= '0;
            act_col_q <= '0;
            row_q     <= '0;
            chk_c_q   <= '0;
            chk_r_q   <= '0;
            player_q  <= 1'b0;
            win_r_q   <= 1'b0;
            win_y_q   <= 1'b0;
            winner_q  <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (keyValid) begin
                        case (keypadButton)
                            KEY_LEFT:  if (cur_col_q != 3'd0) cur_col_q <= cur_col_q - 3'd1;
                            KEY_RIGHT: if (cur_col_q != 3'(COLS-1)) cur_col_q <= cur_col_q + 3'd1;
                            KEY_DROP, KEY_POP: begin
                                act_col_q <= cur_col_q;
                                row_q     <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_DROP: begin
                    if (cur_empty) begin
                        piece_q[cur_idx] <= 1'b1;
                        side_q[cur_idx]  <= player_q;
                    end else if (!row_last) begin
                        row_q <= row_q + ROW_W'(1);
                    end
                end
                S_SHIFT: begin
                    piece_q[cur_idx] <= piece_q[above_idx];
                    side_q[cur_idx]  <= side_q[above_idx];
                    if (shift_last) begin
                        piece_q[top_idx] <= 1'b0;
                        side_q[top_idx]  <= 1'b0;
                    end
                    row_q <= row_q + ROW_W'(1);
                end
                S_CHECK: begin
                    win_r_q <= win_r_q | line_r;
                    win_y_q <= win_y_q | line_y;
                    if (chk_r_q == ROW_W'(ROWS-1)) begin
                        chk_r_q <= '0;
                        chk_c_q <= chk_c_q + 3'd1;
                    end else begin
                        chk_r_q <= chk_r_q + ROW_W'(1);
                    end
                end
                S_RESOLVE: begin
                    if (red_wins)        winner_q <= 2'b01;
                    else if (yel_wins)   winner_q <= 2'b10;
                    else if (board_full) winner_q <= 2'b11;
                    else                 player_q <= ~player_q;
                end
                S_OVER: begin
                    if (keyValid && keypadButton == KEY_NEW) begin
                        piece_q   <= '0;
                        side_q    <= '0;
                        winner_q  <= 2'b00;
                        player_q  <= 1'b0;
                        cur_col_q <= '0;
                    end
                end
                default: ;
            endcase
            if (state_d == S_CHECK && state_q != S_CHECK) begin
                chk_c_q <= '0;
                chk_r_q <= '0;
                win_r_q <= 1'b0;
                win_y_q <= 1'b0;
            end
        end
    end

    // The clear takes priority over a same-cycle win increment.
    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            score_r_q <= '0;
            score_y_q <= '0;
        end else if (resetScore) begin
            score_r_q <= '0;
            score_y_q <= '0;
        end else if (state_q == S_RESOLVE) begin
            if (red_wins && score_r_q != '1) score_r_q <= score_r_q + SCORE_W'(1);
            if (yel_wins && score_y_q != '1) score_y_q <= score_y_q + SCORE_W'(1);
        end
    end

    assign boardPiece  = piece_q;
    assign boardSide   = side_q;
    assign currColumn  = cur_col_q;
    assign currPlayer  = player_q;
    assign busy        = busy_q;
    assign gameOver    = over_q;
    assign winner      = winner_q;
    assign scoreRed    = score_r_q;
    assign scoreYellow = score_y_q;

endmodule

// File: tb/tb_connect4_game_ctrl.sv
// Bench for connect4_game_ctrl: directed game scenarios plus random key presses against a board model.
module tb_connect4_game_ctrl;

    localparam int COLS    = 7;
    localparam int ROWS    = 6;
    localparam int SCORE_W = 4;
    localparam int NCELL   = COLS * ROWS;
    localparam int BUSY_LIMIT = 200;

    logic                 clock = 1'b0;
    logic                 resetGame_n;
    logic                 keyValid;
    logic [3:0]           keypadButton;
    logic                 resetScore;
    logic [NCELL-1:0]     boardPiece, boardSide;
    logic [2:0]           currColumn;
    logic                 currPlayer, busy, gameOver;
    logic [1:0]           winner;
    logic [SCORE_W-1:0]   scoreRed, scoreYellow;

    always #5 clock = ~clock;

    connect4_game_ctrl #(.COLS(COLS), .ROWS(ROWS), .SCORE_W(SCORE_W)) dut (
        .clock(clock), .resetGame_n(resetGame_n), .keyValid(keyValid),
        .keypadButton(keypadButton), .resetScore(resetScore),
        .boardPiece(boardPiece), .boardSide(boardSide), .currColumn(currColumn),
        .currPlayer(currPlayer), .busy(busy), .gameOver(gameOver), .winner(winner),
        .scoreRed(scoreRed), .scoreYellow(scoreYellow)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: 0 empty, 1 red, 2 yellow.
    int brd [COLS][ROWS];
    int m_col, m_player, m_winner, m_sr, m_sy;
    bit m_over;

    function automatic void m_clear_board();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) brd[c][r] = 0;
    endfunction

    function automatic void m_reset();
        m_clear_board();
        m_col = 0; m_player = 0; m_winner = 0; m_sr = 0; m_sy = 0; m_over = 0;
    endfunction

    function automatic bit m_four(input int who);
        int dcs [4];
        int drs [4];
        int cc, rr;
        bit ok;
        dcs = '{1, 0, 1, 1};
        drs = '{0, 1, 1, -1};
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                for (int d = 0; d < 4; d++) begin
                    ok = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        cc = c + dcs[d] * i;
                        rr = r + drs[d] * i;
                        if (cc < 0 || cc >= COLS || rr < 0 || rr >= ROWS) ok = 1'b0;
                        else if (brd[cc][rr] != who) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic bit m_full();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (brd[c][r] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_land(input int c);
        for (int r = 0; r < ROWS; r++)
            if (brd[c][r] == 0) return r;
        return -1;
    endfunction

    function automatic void m_resolve(input bit rs);
        bit wr, wy;
        int w;
        wr = m_four(1);
        wy = m_four(2);
        if (wr && wy)   w = m_player + 1;
        else if (wr)    w = 1;
        else if (wy)    w = 2;
        else if (m_full()) w = 3;
        else            w = 0;
        if (w == 1 && m_sr < (1 << SCORE_W) - 1) m_sr++;
        if (w == 2 && m_sy < (1 << SCORE_W) - 1) m_sy++;
        if (w != 0) begin
            m_winner = w;
            m_over   = 1'b1;
        end else begin
            m_player = 1 - m_player;
        end
        if (rs) begin
            m_sr = 0;
            m_sy = 0;
        end
    endfunction

    // Returns expected busy cycles for the key, or -1 when not checked.
    function automatic int m_apply(input logic [3:0] k, input bit rs);
        int r;
        if (m_over) begin
            if (k == 4'hF) begin
                m_clear_board();
                m_winner = 0; m_player = 0; m_col = 0; m_over = 1'b0;
            end
            return 0;
        end
        case (k)
            4'h4: begin if (m_col > 0) m_col--; return 0; end
            4'h6: begin if (m_col < COLS - 1) m_col++; return 0; end
            4'h5: begin
                r = m_land(m_col);
                if (r < 0) return ROWS;
                brd[m_col][r] = m_player + 1;
                m_resolve(rs);
                return r + 1 + NCELL + 1;
            end
            4'h8: begin
                if (brd[m_col][0] == m_player + 1) begin
                    for (int i = 0; i < ROWS - 1; i++) brd[m_col][i] = brd[m_col][i+1];
                    brd[m_col][ROWS-1] = 0;
                    m_resolve(rs);
                end
                return -1;
            end
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NCELL-1:0] ep, es;
        ep = '0;
        es = '0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) begin
                ep[c*ROWS+r] = (brd[c][r] != 0);
                es[c*ROWS+r] = (brd[c][r] == 2);
            end
        chk({tag, " piece"},  64'(boardPiece),  64'(ep));
        chk({tag, " side"},   64'(boardSide),   64'(es));
        chk({tag, " column"}, 64'(currColumn),  64'(m_col));
        chk({tag, " player"}, 64'(currPlayer),  64'(m_player));
        chk({tag, " busy"},   64'(busy),        64'(0));
        chk({tag, " over"},   64'(gameOver),    64'(m_over));
        chk({tag, " winner"}, 64'(winner),      64'(m_winner));
        chk({tag, " score_r"},64'(scoreRed),    64'(m_sr));
        chk({tag, " score_y"},64'(scoreYellow), 64'(m_sy));
    endtask

    task automatic do_key(input logic [3:0] k, input int rs_at, output int nbusy);
        @(negedge clock);
        keyValid = 1'b1;
        keypadButton = k;
        @(negedge clock);
        keyValid = 1'b0;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < BUSY_LIMIT) begin
            nbusy++;
            resetScore = (nbusy == rs_at);
            @(negedge clock);
            resetScore = 1'b0;
        end
    endtask

    task automatic press(input logic [3:0] k, input int rs_at, input string tag);
        int nb, eb;
        do_key(k, rs_at, nb);
        eb = m_apply(k, rs_at > 0);
        if (eb >= 0) chk({tag, " busy_cycles"}, 64'(nb), 64'(eb));
        check_all(tag);
    endtask

    task automatic goto_col(input int c);
        while (m_col < c) press(4'h6, 0, "move right");
        while (m_col > c) press(4'h4, 0, "move left");
    endtask

    task automatic drop_at(input int c, input string tag);
        goto_col(c);
        press(4'h5, 0, tag);
    endtask

    task automatic hard_reset(input string tag);
        @(negedge clock);
        resetGame_n = 1'b0;
        #1;
        m_reset();
        check_all({tag, " in reset"});
        @(negedge clock);
        resetGame_n = 1'b1;
        repeat (3) @(negedge clock);
        check_all({tag, " after reset"});
    endtask

    task automatic reset_mid(input logic [3:0] k, input int wait_n, input string tag);
        @(negedge clock);
        keyValid = 1'b1;
        keypadButton = k;
        @(negedge clock);
        keyValid = 1'b0;
        repeat (wait_n) @(negedge clock);
        chk({tag, " busy mid"}, 64'(busy), 64'(1));
        hard_reset(tag);
    endtask

    int          build_cols [14];
    int          rnd, rs_pick, lr;
    logic [3:0]  rkey;

    initial begin
        resetGame_n  = 1'b0;
        keyValid     = 1'b0;
        keypadButton = 4'h0;
        resetScore   = 1'b0;
        m_reset();
        repeat (2) @(negedge clock);
        check_all("reset");
        resetGame_n = 1'b1;
        repeat (3) @(negedge clock);

        // Cursor saturation
        for (int i = 0; i < 7; i++) press(4'h6, 0, "right");
        press(4'h4, 0, "left");

        drop_at(2, "drop first");
        press(4'h5, 0, "drop second");

        goto_col(3);
        for (int i = 0; i < 6; i++) press(4'h5, 0, "fill col3");
        press(4'h5, 0, "full col3");

        // Red horizontal win
        hard_reset("clean");
        for (int i = 0; i < 3; i++) begin
            drop_at(i, "red row");
            drop_at(6, "yellow col6");
        end
        drop_at(3, "red wins");
        press(4'h5, 0, "drop in over");
        press(4'hF, 0, "new game");

        // Pop: opponent bottom, then own piece
        drop_at(2, "pop setup r");
        press(4'h8, 0, "pop opponent");
        press(4'h5, 0, "pop setup y");
        press(4'h5, 0, "pop setup r2");
        drop_at(5, "pop setup y2");
        goto_col(2);
        press(4'h8, 0, "pop own");

        // Pop completing fours for both sides
        hard_reset("pop both");
        build_cols = '{1, 0, 1, 2, 0, 0, 2, 1, 3, 3, 3, 2, 6, 3};
        for (int i = 0; i < 14; i++) drop_at(build_cols[i], "build");
        goto_col(3);
        press(4'h8, 0, "pop double four");

        // Reset mid-SHIFT and mid-CHECK
        press(4'hF, 0, "new game 2");
        drop_at(0, "shift setup r");
        drop_at(1, "shift setup y");
        goto_col(0);
        reset_mid(4'h8, 2, "rst shift");
        drop_at(4, "check setup");
        reset_mid(4'h5, 20, "rst check");

        // resetScore in the resolve cycle of a win
        for (int i = 0; i < 3; i++) begin
            drop_at(i, "red row b");
            drop_at(6, "yellow col6 b");
        end
        drop_at(3, "red wins b");
        press(4'hF, 0, "new game 3");
        for (int i = 0; i < 3; i++) begin
            drop_at(i, "red row c");
            drop_at(6, "yellow col6 c");
        end
        goto_col(3);
        press(4'h5, m_land(3) + NCELL + 2, "win with score clear");
        press(4'hF, 0, "new game 4");

        // Random play
        for (int i = 0; i < 150; i++) begin
            rnd = $urandom_range(0, 9);
            case (rnd)
                0, 1:    rkey = 4'h4;
                2, 3:    rkey = 4'h6;
                4, 5, 6: rkey = 4'h5;
                7:       rkey = 4'h8;
                8:       rkey = 4'hF;
                default: rkey = 4'h2;
            endcase
            rs_pick = 0;
            lr = m_land(m_col);
            if (rkey == 4'h5 && !m_over && lr >= 0 && $urandom_range(0, 15) == 0)
                rs_pick = lr + NCELL + 2;
            press(rkey, rs_pick, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
